// File: rtl/seq_div_if.sv
// Operand/result bundle for the sequential divider.
//   master: drives start, dividend, divisor; observes busy, done and the result.
//   slave : the divider itself.
interface seq_div_if #(
  parameter int unsigned N = 8
);
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_div.sv
// Sequential restoring divider: one quotient bit per clock, N-bit unsigned
// operands, N-bit quotient and remainder with a one-cycle done pulse.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    seq_div_if.slave: start/dividend/divisor in;
//          busy/done/quotient/remainder/div_by_zero out (all registered)
// Optional feature macro: SEQ_DIV_DBZ_EN -- when defined, a zero divisor
// skips iteration, completes one edge after start and raises div_by_zero.
// When undefined, a zero divisor runs the full N steps and div_by_zero is 0.
module seq_div #(
  parameter int unsigned N = 8
) (
  input logic     clk,
  input logic     rst_n,
  seq_div_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(N);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  // The partial remainder is always below the divisor, so its top bit is
  // always zero; only the low N bits are stored.
  logic [N-1:0]     r_q;
  logic [N-1:0]     q_q;
  logic [N-1:0]     d_q;

  logic             busy_q;
  logic             done_q;
  logic [N-1:0]     quot_q;
  logic [N-1:0]     rem_q;
`ifdef SEQ_DIV_DBZ_EN
  logic             dbz_q;
`endif

  logic [N:0]       t_c;
  logic             ge_c;
  logic [N-1:0]     r_nxt_c;
  logic [N-1:0]     q_nxt_c;

  // One restoring step: N+1-bit trial subtraction, never wraps.
  always_comb begin
    t_c     = {r_q, q_q[N-1]};
    ge_c    = (t_c >= {1'b0, d_q});
    r_nxt_c = ge_c ? N'(t_c - {1'b0, d_q}) : N'(t_c);
    q_nxt_c = {q_q[N-2:0], ge_c};
  end

  // Control, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
`ifdef SEQ_DIV_DBZ_EN
      dbz_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_q   <= '0;
            q_q   <= bus.dividend;
            d_q   <= bus.divisor;
            cnt_q <= '0;
`ifdef SEQ_DIV_DBZ_EN
            if (bus.divisor == '0) begin
              // Same values the plain algorithm would produce, one edge later.
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              quot_q  <= '1;
              rem_q   <= bus.dividend;
              dbz_q   <= 1'b1;
            end else
`endif
            begin
              state_q <= S_RUN;
              busy_q  <= 1'b1;
            end
          end else begin
            state_q <= S_IDLE;
          end
        end

        S_RUN: begin
          r_q   <= r_nxt_c;
          q_q   <= q_nxt_c;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_STEP) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            quot_q  <= q_nxt_c;
            rem_q   <= r_nxt_c;
`ifdef SEQ_DIV_DBZ_EN
            dbz_q   <= 1'b0;
`endif
          end
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.quotient  = quot_q;
  assign bus.remainder = rem_q;
`ifdef SEQ_DIV_DBZ_EN
  assign bus.div_by_zero = dbz_q;
`else
  assign bus.div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_seq_div.sv
// Directed self-checking bench for seq_div (N=8).
module tb_seq_div;

  localparam int unsigned N = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   dones;

  seq_div_if #(.N(N)) bus ();

  seq_div #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_done"}, 32'(bus.done), 32'd0);
    chk({tag, "_quot"}, 32'(bus.quotient), 32'd0);
    chk({tag, "_rem"},  32'(bus.remainder), 32'd0);
    chk({tag, "_dbz"},  32'(bus.div_by_zero), 32'd0);
  endtask

  // Issue one division; check busy each cycle, done in cycle lat, then one
  // cycle later done low and result held.
  task automatic run_div(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] eq, input logic [7:0] er,
                         input logic edbz, input int lat);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    step();
    bus.start    = 1'b0;
    bus.dividend = 8'hA5;
    bus.divisor  = 8'h3C;
    for (int k = 0; k < lat; k++) begin
      chk({tag, "_busy_run"}, 32'(bus.busy), 32'd1);
      chk({tag, "_done_run"}, 32'(bus.done), 32'd0);
      step();
    end
    chk({tag, "_done"}, 32'(bus.done), 32'd1);
    chk({tag, "_busy_done"}, 32'(bus.busy), 32'd0);
    chk({tag, "_quot"}, 32'(bus.quotient), 32'(eq));
    chk({tag, "_rem"},  32'(bus.remainder), 32'(er));
    chk({tag, "_dbz"},  32'(bus.div_by_zero), 32'(edbz));
    step();
    chk({tag, "_done_after"}, 32'(bus.done), 32'd0);
    chk({tag, "_quot_held"}, 32'(bus.quotient), 32'(eq));
    chk({tag, "_rem_held"},  32'(bus.remainder), 32'(er));
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;

    // Reset state
    step();
    step();
    chk_zero("reset");
    rst_n = 1'b1;
    step();
    chk_zero("idle");

    // Basic vectors
    run_div("d200_7",  8'd200, 8'd7,   8'd28,  8'd4,   1'b0, 8);
    run_div("d255_1",  8'd255, 8'd1,   8'd255, 8'd0,   1'b0, 8);
    run_div("d5_9",    8'd5,   8'd9,   8'd0,   8'd5,   1'b0, 8);
    run_div("d255_255",8'd255, 8'd255, 8'd1,   8'd0,   1'b0, 8);

    // Divide by zero
`ifdef SEQ_DIV_DBZ_EN
    run_div("d100_0",  8'd100, 8'd0,   8'd255, 8'd100, 1'b1, 0);
`else
    run_div("d100_0",  8'd100, 8'd0,   8'd255, 8'd100, 1'b0, 8);
`endif
    // div_by_zero clears on the next nonzero-divisor completion
    run_div("d200_7b", 8'd200, 8'd7,   8'd28,  8'd4,   1'b0, 8);

    // start during RUN is ignored
    bus.start    = 1'b1;
    bus.dividend = 8'd200;
    bus.divisor  = 8'd7;
    step();
    dones = 0;
    for (int k = 0; k <= 12; k++) begin
      if (k >= 3 && k <= 5) begin
        bus.start    = 1'b1;
        bus.dividend = 8'd50;
        bus.divisor  = 8'd5;
      end else begin
        bus.start    = 1'b0;
      end
      if (k == 8) begin
        chk("ign_done", 32'(bus.done), 32'd1);
        chk("ign_quot", 32'(bus.quotient), 32'd28);
        chk("ign_rem",  32'(bus.remainder), 32'd4);
      end
      if (bus.done) dones++;
      step();
    end
    chk("ign_done_count", 32'(dones), 32'd1);

    // Back-to-back with start held high
    bus.start    = 1'b1;
    bus.dividend = 8'd200;
    bus.divisor  = 8'd7;
    step();
    bus.dividend = 8'd50;
    bus.divisor  = 8'd5;
    dones = 0;
    for (int k = 0; k <= 17; k++) begin
      if (k == 8) begin
        chk("b2b_done1", 32'(bus.done), 32'd1);
        chk("b2b_quot1", 32'(bus.quotient), 32'd28);
        chk("b2b_rem1",  32'(bus.remainder), 32'd4);
      end
      if (k == 9) chk("b2b_busy_no_gap", 32'(bus.busy), 32'd1);
      if (k == 16) chk("b2b_quot_held", 32'(bus.quotient), 32'd28);
      if (k == 17) begin
        chk("b2b_done2", 32'(bus.done), 32'd1);
        chk("b2b_quot2", 32'(bus.quotient), 32'd10);
        chk("b2b_rem2",  32'(bus.remainder), 32'd0);
      end
      if (bus.done) dones++;
      if (k == 17) bus.start = 1'b0;
      step();
    end
    chk("b2b_done_count", 32'(dones), 32'd2);

    // Reset in the middle of a run
    bus.start    = 1'b1;
    bus.dividend = 8'd200;
    bus.divisor  = 8'd7;
    step();
    bus.start = 1'b0;
    for (int k = 0; k < 4; k++) step();
    chk("rst_mid_busy_before", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    step();
    chk_zero("rst_mid");
    rst_n = 1'b1;
    dones = 0;
    for (int k = 0; k < 12; k++) begin
      if (bus.done) dones++;
      step();
    end
    chk("rst_mid_no_done", 32'(dones), 32'd0);
    chk("rst_mid_quot_hold", 32'(bus.quotient), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_div.md
# seq_div

Sequential restoring divider: the inverse of the team's registered array multiplier. It accepts an unsigned N-bit dividend and divisor with a start pulse and resolves one quotient bit per clock. It returns an N-bit quotient and an N-bit remainder with a one-cycle done pulse. It sits beside the multiplier in the arithmetic datapath and serves the same operand and result widths in the reverse direction.

## Interface
- N, default 8: operand width in bits; must be ≥ 2.
- clk  in  1  rising-edge clock; all state is updated on this edge.
- rst_n  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- start  in  1  request; sampled only while idle.
- dividend  in  N  unsigned dividend; captured on the accepted start edge.
- divisor  in  N  unsigned divisor; captured on the accepted start edge.
- busy  out  1  high while iterating.
- done  out  1  one-cycle pulse; high in the cycle when a new result first appears.
- quotient  out  N  registered quotient; held until the next completion.
- remainder  out  N  registered remainder; held until the next completion.
- div_by_zero  out  1  registered flag; valid with done and held with the result.

## Operation
- States: IDLE, RUN, DONE.
- IDLE + start=1: capture operands, clear the iteration counter, go to RUN. IDLE + start=0: stay in IDLE.
- Internal registers:
  - R: partial remainder, N+1 bits, cleared on start.
  - Q: shift register, loaded with the dividend.
  - D: divisor, zero-extended to N+1 bits.
- RUN step, repeated N times:
  - T = {R[N-1:0], Q[N-1]}.
  - If T ≥ D: R ← T − D and shift a 1 into Q[0]. Otherwise: R ← T and shift a 0 into Q[0].
  - The trial subtraction is N+1 bits wide and never wraps.
- After the Nth step: go to DONE; quotient ← Q and remainder ← R[N-1:0].
- DONE: done=1 for exactly this one cycle.
  - start=1: accept new operands and go to RUN (back-to-back operation).
  - start=0: go to IDLE.
- start while in RUN: ignored; no effect on operands or progress.
- Divisor 0 with the plain algorithm yields quotient = all ones and remainder = dividend. Those values are architectural in both configurations.
- Reset (rst_n=0 at an edge): state ← IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0. Any operation in flight is abandoned and produces no done.

## Timing
- start is sampled high at edge E0. Cycle k is the cycle following edge Ek.
- busy=1 in cycles 0..N−1 (N cycles). busy=0 in IDLE and DONE.
- done=1 in cycle N, after edge EN. The outputs change on the same edge EN.
- Latency from start to done is N+1 edges (9 for N=8).
- Throughput: one result every N+1 cycles when start is held high or re-pulsed in DONE.
- Output reset values: all zero, as listed under Operation.
- Outputs change only on completion or reset; they are stable otherwise.

## Configuration
- Macro: SEQ_DIV_DBZ_EN.
- Defined:
  - On accepted start with divisor==0, RUN is skipped; the next state is DONE.
  - done=1 in cycle 0, one edge after start.
  - Outputs: div_by_zero=1, quotient = all ones, remainder = dividend.
  - div_by_zero clears on the next completion with a nonzero divisor.
- Undefined:
  - Divisor 0 runs the full N steps with the standard latency.
  - Same quotient and remainder values as when defined.
  - div_by_zero is tied to 0.

## Test plan
- N=8, reset, then 200/7 → busy cycles 0–7, done in cycle 8, quotient=28, remainder=4, div_by_zero=0.
- 255/1 → quotient=255, remainder=0. 5/9 → quotient=0, remainder=5. 255/255 → quotient=1, remainder=0.
- 100/0:
  - With SEQ_DIV_DBZ_EN: done in cycle 0, div_by_zero=1, quotient=255, remainder=100.
  - Without it: done in cycle 8, div_by_zero=0, same quotient and remainder.
- 200/7 started, then start=1 with 50/5 in cycles 3–5 → result is still 28 r 4 at cycle 8, with exactly one done pulse.
- start held high through DONE with 50/5 → 28 r 4 at cycle 8, then 10 r 0 nine cycles later, with no idle cycle between.
- rst_n=0 during cycle 4 of a run → the next cycle shows busy=0, done=0 and all outputs 0; no done pulse follows.
